// File: rtl/period_meter.sv
// Measures one period and high time of an asynchronous square wave in clk cycles.
// Optional macro PERIOD_METER_CONT_EN keeps measuring back-to-back periods after one start.
module period_meter #(
    parameter int unsigned      CNT_W   = 32,
    parameter logic [CNT_W-1:0] TIMEOUT = 32'hFFFF_FFFE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             valid,
    output logic             timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    // Abort on the edge that would bring cnt up to TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT - CNT_ONE;

    state_t           state_r;
    state_t           state_nx_s;
    logic             sync1_r;
    logic             sync2_r;
    logic             prev_r;
    logic             rise_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] hcnt_r;
    logic [CNT_W-1:0] cnt_nx_s;
    logic [CNT_W-1:0] hcnt_nx_s;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] high_r;
    logic             busy_r;
    logic             valid_r;
    logic             timeout_r;
    logic             close_s;
    logic             abort_s;
    logic             at_limit_s;

    assign at_limit_s = (cnt_r == CNT_LAST);

    // Two-flop synchronizer, delayed copy and registered rising-edge strobe.
    // rise_r and prev_r line up in time, so prev_r is the level seen by the counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            rise_r  <= 1'b0;
        end else begin
            sync1_r <= sig_in;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            rise_r  <= sync2_r & ~prev_r;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; a closing rise takes priority over the abort limit.
    always_comb begin
        state_nx_s = state_r;
        close_s    = 1'b0;
        abort_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_ARM;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (rise_r) begin
                    state_nx_s = ST_MEASURE;
                end else if (at_limit_s) begin
                    state_nx_s = ST_IDLE;
                    abort_s    = 1'b1;
                end else begin
                    state_nx_s = ST_ARM;
                end
            end
            ST_MEASURE: begin
                if (rise_r) begin
                    close_s = 1'b1;
`ifdef PERIOD_METER_CONT_EN
                    state_nx_s = ST_MEASURE;
`else
                    state_nx_s = ST_IDLE;
`endif
                end else if (at_limit_s) begin
                    state_nx_s = ST_IDLE;
                    abort_s    = 1'b1;
                end else begin
                    state_nx_s = ST_MEASURE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Counter next values; each rise seen while armed or measuring opens a window at 1.
    always_comb begin
        cnt_nx_s  = cnt_r;
        hcnt_nx_s = hcnt_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nx_s  = CNT_ZERO;
                hcnt_nx_s = CNT_ZERO;
            end
            ST_ARM: begin
                if (rise_r) begin
                    cnt_nx_s  = CNT_ONE;
                    hcnt_nx_s = CNT_ONE;
                end else begin
                    cnt_nx_s  = cnt_r + CNT_ONE;
                    hcnt_nx_s = CNT_ZERO;
                end
            end
            ST_MEASURE: begin
                if (rise_r) begin
                    cnt_nx_s  = CNT_ONE;
                    hcnt_nx_s = CNT_ONE;
                end else if (prev_r) begin
                    cnt_nx_s  = cnt_r + CNT_ONE;
                    hcnt_nx_s = hcnt_r + CNT_ONE;
                end else begin
                    cnt_nx_s  = cnt_r + CNT_ONE;
                    hcnt_nx_s = hcnt_r;
                end
            end
            default: begin
                cnt_nx_s  = CNT_ZERO;
                hcnt_nx_s = CNT_ZERO;
            end
        endcase
    end

    // Counters and registered outputs; results only change on a closing rise.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r     <= CNT_ZERO;
            hcnt_r    <= CNT_ZERO;
            period_r  <= CNT_ZERO;
            high_r    <= CNT_ZERO;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_nx_s;
            hcnt_r    <= hcnt_nx_s;
            busy_r    <= (state_nx_s != ST_IDLE);
            valid_r   <= close_s;
            timeout_r <= abort_s;
            if (close_s) begin
                period_r <= cnt_r;
                high_r   <= hcnt_r;
            end else begin
                period_r <= period_r;
                high_r   <= high_r;
            end
        end
    end

    assign busy       = busy_r;
    assign period_out = period_r;
    assign high_out   = high_r;
    assign valid      = valid_r;
    assign timeout    = timeout_r;

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: dut_a uses the default TIMEOUT, dut_b uses TIMEOUT=100.
// Continuous-mode expectations are selected by PERIOD_METER_CONT_EN.
module tb_period_meter;

    typedef struct {
        int unsigned p;
        int unsigned h;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sig_in;
    logic        start_a;
    logic        start_b;
    logic        busy_a, valid_a, timeout_a;
    logic        busy_b, valid_b, timeout_b;
    logic [31:0] period_a, high_a, period_b, high_b;

    int unsigned cyc = 0;
    int unsigned wave_period = 1;
    int unsigned wave_high = 0;
    int unsigned wave_gen = 0;
    int unsigned rise_cyc = 0;
    bit          wave_en = 1'b0;
    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    period_meter #(.CNT_W(32)) dut_a (
        .clk(clk), .reset_n(reset_n), .sig_in(sig_in), .start(start_a),
        .busy(busy_a), .period_out(period_a), .high_out(high_a),
        .valid(valid_a), .timeout(timeout_a)
    );

    period_meter #(.CNT_W(32), .TIMEOUT(32'd100)) dut_b (
        .clk(clk), .reset_n(reset_n), .sig_in(sig_in), .start(start_b),
        .busy(busy_b), .period_out(period_b), .high_out(high_b),
        .valid(valid_b), .timeout(timeout_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Square-wave source, changing 2 ns after the clock edge; restarts its phase on a new wave_gen.
    initial begin
        int unsigned ph;
        int unsigned seen_gen;
        bit          nxt;
        ph = 0;
        seen_gen = 0;
        sig_in = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (wave_gen != seen_gen) begin
                seen_gen = wave_gen;
                ph = 0;
            end
            if (!wave_en) begin
                sig_in = 1'b0;
            end else begin
                nxt = (ph < wave_high);
                if (nxt && !sig_in) rise_cyc = cyc;
                sig_in = nxt;
                ph = (ph + 1 >= wave_period) ? 0 : ph + 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wave_off();
        wave_en = 1'b0;
        tick(8);
    endtask

    task automatic set_wave(input int unsigned p, input int unsigned h);
        wave_off();
        wave_period = p;
        wave_high = h;
        wave_gen++;
        wave_en = 1'b1;
    endtask

    task automatic pulse_start(input bit sel_b);
        if (sel_b) start_b = 1'b1;
        else start_a = 1'b1;
        tick(1);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic push_exp(input int unsigned p, input int unsigned h);
        exp_t e;
        e.p = p;
        e.h = h;
        sb.push_back(e);
    endtask

    task automatic wait_valid(input bit sel_b, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick(1);
            seen = sel_b ? valid_b : valid_a;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        tick(3);
        n_cmp++; if ({busy_a, valid_a, timeout_a} !== 3'b000) begin n_bad++; $display("FAIL reset_flags_a: got %b want 000", {busy_a, valid_a, timeout_a}); end
        n_cmp++; if (period_a !== 32'd0 || high_a !== 32'd0) begin n_bad++; $display("FAIL reset_outs_a: got %0d/%0d want 0/0", period_a, high_a); end
        n_cmp++; if ({busy_b, valid_b, timeout_b} !== 3'b000) begin n_bad++; $display("FAIL reset_flags_b: got %b want 000", {busy_b, valid_b, timeout_b}); end
        n_cmp++; if (period_b !== 32'd0 || high_b !== 32'd0) begin n_bad++; $display("FAIL reset_outs_b: got %0d/%0d want 0/0", period_b, high_b); end
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_asym();
        bit   seen;
        exp_t e;
        set_wave(7, 1);
        pulse_start(1'b1);
        push_exp(7, 1);
`ifdef PERIOD_METER_CONT_EN
        push_exp(7, 1);
`endif
        while (sb.size() > 0) begin
            wait_valid(1'b1, 40, seen);
            n_cmp++;
            if (!seen) begin
                n_bad++;
                $display("FAIL asym_valid: got no valid want valid within 40 cycles");
                sb.delete();
            end else begin
                e = sb.pop_front();
                n_cmp++; if (period_b !== e.p) begin n_bad++; $display("FAIL asym_period: got %0d want %0d", period_b, e.p); end
                n_cmp++; if (high_b !== e.h) begin n_bad++; $display("FAIL asym_high: got %0d want %0d", high_b, e.h); end
                n_cmp++; if (cyc - rise_cyc !== 32'd4) begin n_bad++; $display("FAIL asym_latency: got %0d want 4", cyc - rise_cyc); end
            end
        end
`ifdef PERIOD_METER_CONT_EN
        n_cmp++; if (busy_b !== 1'b1) begin n_bad++; $display("FAIL asym_busy_cont: got %b want 1", busy_b); end
        wave_en = 1'b0;
        begin
            int got_to;
            got_to = 0;
            for (int i = 0; i < 150 && got_to == 0; i++) begin
                tick(1);
                if (timeout_b) got_to = 1;
            end
            n_cmp++; if (got_to != 1) begin n_bad++; $display("FAIL asym_cont_timeout: got none want timeout pulse"); end
            n_cmp++; if (period_b !== 32'd7 || high_b !== 32'd1) begin n_bad++; $display("FAIL asym_hold: got %0d/%0d want 7/1", period_b, high_b); end
        end
        tick(1);
`else
        n_cmp++; if (busy_b !== 1'b0) begin n_bad++; $display("FAIL asym_busy: got %b want 0", busy_b); end
`endif
    endtask

    task automatic run_timeout(input string name);
        int first, pulses, vseen;
        logic busy_at;
        logic [31:0] per_at, high_at;
        first = 0;
        pulses = 0;
        vseen = 0;
        busy_at = 1'b1;
        per_at = 32'd0;
        high_at = 32'd0;
        pulse_start(1'b1);
        n_cmp++; if (busy_b !== 1'b1) begin n_bad++; $display("FAIL %s_busy: got %b want 1", name, busy_b); end
        for (int k = 1; k <= 110; k++) begin
            tick(1);
            if (timeout_b) begin
                pulses++;
                if (first == 0) first = k;
            end
            if (valid_b) vseen++;
            if (k == 100) begin
                busy_at = busy_b;
                per_at = period_b;
                high_at = high_b;
            end
        end
        n_cmp++; if (first != 100) begin n_bad++; $display("FAIL %s_cycle: got %0d want 100", name, first); end
        n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL %s_width: got %0d want 1", name, pulses); end
        n_cmp++; if (vseen != 0) begin n_bad++; $display("FAIL %s_novalid: got %0d want 0", name, vseen); end
        n_cmp++; if (busy_at !== 1'b0) begin n_bad++; $display("FAIL %s_idle: got %b want 0", name, busy_at); end
        n_cmp++; if (per_at !== 32'd7 || high_at !== 32'd1) begin n_bad++; $display("FAIL %s_hold: got %0d/%0d want 7/1", name, per_at, high_at); end
    endtask

    task automatic test_timeout();
        wave_off();
        run_timeout("timeout_low");
        set_wave(1, 1);
        tick(8);
        run_timeout("timeout_high");
    endtask

    task automatic test_single();
        bit   seen;
        exp_t e;
        set_wave(10000, 5000);
        pulse_start(1'b0);
        push_exp(10000, 5000);
        wait_valid(1'b0, 10100, seen);
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL single_valid: got no valid want valid within 10100 cycles");
            sb.delete();
        end else begin
            e = sb.pop_front();
            n_cmp++; if (period_a !== e.p) begin n_bad++; $display("FAIL single_period: got %0d want %0d", period_a, e.p); end
            n_cmp++; if (high_a !== e.h) begin n_bad++; $display("FAIL single_high: got %0d want %0d", high_a, e.h); end
            n_cmp++; if (cyc - rise_cyc !== 32'd4) begin n_bad++; $display("FAIL single_latency: got %0d want 4", cyc - rise_cyc); end
`ifdef PERIOD_METER_CONT_EN
            n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy_a); end
`else
            n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL single_busy: got %b want 0", busy_a); end
`endif
            tick(1);
            n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("FAIL single_pulse: got %b want 0", valid_a); end
        end
    endtask

    task automatic test_start_ignored();
        bit   seen;
        exp_t e;
        int   extra;
`ifdef PERIOD_METER_CONT_EN
        do_reset();
`endif
        set_wave(10000, 5000);
        pulse_start(1'b0);
        push_exp(10000, 5000);
        tick(55);
        pulse_start(1'b0);
        wait_valid(1'b0, 10100, seen);
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL restart_valid: got no valid want valid within 10100 cycles");
            sb.delete();
        end else begin
            e = sb.pop_front();
            n_cmp++; if (period_a !== e.p) begin n_bad++; $display("FAIL restart_period: got %0d want %0d", period_a, e.p); end
            n_cmp++; if (high_a !== e.h) begin n_bad++; $display("FAIL restart_high: got %0d want %0d", high_a, e.h); end
        end
        extra = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (valid_a || timeout_a) extra++;
        end
        n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL restart_extra: got %0d pulses want 0", extra); end
    endtask

    task automatic test_reset_mid();
        bit   seen;
        exp_t e;
        int   stray;
`ifndef PERIOD_METER_CONT_EN
        set_wave(200, 80);
        pulse_start(1'b0);
`endif
        tick(50);
        reset_n = 1'b0;
        tick(1);
        n_cmp++; if ({busy_a, valid_a, timeout_a} !== 3'b000) begin n_bad++; $display("FAIL rstmid_flags: got %b want 000", {busy_a, valid_a, timeout_a}); end
        n_cmp++; if (period_a !== 32'd0 || high_a !== 32'd0) begin n_bad++; $display("FAIL rstmid_outs: got %0d/%0d want 0/0", period_a, high_a); end
        reset_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 250; i++) begin
            tick(1);
            if (valid_a || timeout_a || busy_a) stray++;
        end
        n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", stray); end
        set_wave(200, 80);
        pulse_start(1'b0);
        push_exp(200, 80);
        wait_valid(1'b0, 500, seen);
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL rstmid_valid: got no valid want valid within 500 cycles");
            sb.delete();
        end else begin
            e = sb.pop_front();
            n_cmp++; if (period_a !== e.p) begin n_bad++; $display("FAIL rstmid_period: got %0d want %0d", period_a, e.p); end
            n_cmp++; if (high_a !== e.h) begin n_bad++; $display("FAIL rstmid_high: got %0d want %0d", high_a, e.h); end
        end
    endtask

    task automatic test_back_to_back();
        bit          seen;
        exp_t        e;
        int unsigned last;
        int          idx;
        int          stray;
`ifdef PERIOD_METER_CONT_EN
        do_reset();
`endif
        set_wave(8, 3);
        pulse_start(1'b0);
        push_exp(8, 3);
`ifdef PERIOD_METER_CONT_EN
        push_exp(8, 3);
        push_exp(8, 3);
        push_exp(8, 3);
`endif
        idx = 0;
        last = 0;
        while (sb.size() > 0) begin
            wait_valid(1'b0, 30, seen);
            n_cmp++;
            if (!seen) begin
                n_bad++;
                $display("FAIL b2b_valid: got no valid want valid within 30 cycles");
                sb.delete();
            end else begin
                e = sb.pop_front();
                n_cmp++; if (period_a !== e.p) begin n_bad++; $display("FAIL b2b_period: got %0d want %0d", period_a, e.p); end
                n_cmp++; if (high_a !== e.h) begin n_bad++; $display("FAIL b2b_high: got %0d want %0d", high_a, e.h); end
                if (idx > 0) begin
                    n_cmp++; if (cyc - last !== 32'd8) begin n_bad++; $display("FAIL b2b_spacing: got %0d want 8", cyc - last); end
                end
                last = cyc;
                idx++;
            end
        end
`ifdef PERIOD_METER_CONT_EN
        n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL b2b_busy: got %b want 1", busy_a); end
        do_reset();
`else
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL b2b_busy: got %b want 0", busy_a); end
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (valid_a) stray++;
        end
        n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL b2b_single: got %0d extra valids want 0", stray); end
`endif
    endtask

    initial begin
        test_reset();
        test_asym();
        test_timeout();
        test_single();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter CNT_W, default 32, width of period/high-time counters and outputs.
REQ-002 Parameter TIMEOUT, default 32'hFFFF_FFFE, max clk cycles spent in ARM or MEASURE before abort; legal range 2..2^CNT_W-2.
REQ-003 clk  input  1  system clock; all logic rising-edge.
REQ-004 reset_n  input  1  synchronous active-low reset.
REQ-005 sig_in  input  1  asynchronous square wave under measurement (e.g. divided clock).
REQ-006 start  input  1  single-cycle request to measure one period; ignored unless IDLE.
REQ-007 busy  output  1  high in ARM and MEASURE.
REQ-008 period_out  output  CNT_W  last measured rising-to-rising period, clk cycles.
REQ-009 high_out  output  CNT_W  last measured high time, clk cycles.
REQ-010 valid  output  1  one-cycle pulse; period_out/high_out updated same cycle.
REQ-011 timeout  output  1  one-cycle pulse on abort; outputs unchanged.

Function
REQ-012 sig_in SHALL pass a 2-flop synchronizer; a third flop holds previous synced value; rise = synced & ~prev.
REQ-013 FSM states SHALL be IDLE, ARM, MEASURE.
REQ-014 IDLE: start=1 -> ARM next cycle; count cleared.
REQ-015 ARM: on rise -> MEASURE, cnt<=1, hcnt<=1; else cnt increments.
REQ-016 MEASURE: each cycle without rise, cnt increments and hcnt increments while synced=1.
REQ-017 MEASURE: on rise, period_out<=cnt, high_out<=hcnt, valid=1 that cycle (registered), state -> IDLE.
REQ-018 Latency: valid SHALL assert 4 clk cycles after the sig_in rising edge that closes the period (2 sync + edge + register).
REQ-019 Period value SHALL equal clk cycles between the two detected rise cycles; high value equals cycles synced=1 within that window.
REQ-020 Counters SHALL be CNT_W bits; abort when cnt reaches TIMEOUT, so no wrap-around is ever observable.
REQ-021 Abort: timeout=1 one cycle, state -> IDLE, period_out/high_out hold prior values, valid stays 0.
REQ-022 start while busy SHALL be ignored with no effect on the measurement.
REQ-023 sig_in constant (0 or 1) after start SHALL end in timeout; stuck-high signal never produces a rise.
REQ-024 Simultaneous rise and cnt==TIMEOUT in MEASURE: rise wins, valid asserted, no timeout.

Reset
REQ-025 reset_n=0 at a clk edge SHALL force IDLE, synchronizer/prev flops to 0, cnt/hcnt/period_out/high_out to 0, busy/valid/timeout to 0.
REQ-026 Reset mid-ARM or mid-MEASURE SHALL discard the partial count; no valid or timeout pulse generated.
REQ-027 First rise after reset SHALL require synced to be seen 0 first (prev reset to 0 permits immediate rise if sig_in already high; accepted behaviour).

Configuration
REQ-028 Macro PERIOD_METER_CONT_EN defined: after valid, FSM SHALL stay in MEASURE with cnt<=1 on the closing rise, producing back-to-back measurements every period without start; busy stays high; timeout still returns to IDLE.
REQ-029 Macro undefined: single-shot operation per REQ-014..REQ-017; continuous logic absent.

Verification
REQ-030 clk 10 ns, sig_in square wave period 10000 clk (5000 high), pulse start -> one valid, period_out=10000, high_out=5000, busy low after.
REQ-031 sig_in held 0, TIMEOUT=100, pulse start -> timeout pulse exactly 100 cycles after ARM entry, valid never asserts, outputs keep prior values.
REQ-032 start pulsed again 50 cycles into MEASURE of 10000-cycle wave -> single valid, period_out=10000.
REQ-033 reset_n=0 for 1 cycle mid-MEASURE -> all outputs 0 next cycle, no valid; new start then measures correctly.
REQ-034 PERIOD_METER_CONT_EN, period 8 clk (3 high), one start -> valid every 8 cycles, period_out=8, high_out=3 each time.
REQ-035 Asymmetric wave period 7 clk, 1 high -> period_out=7, high_out=1.
